// File: rtl/leftright_checker.sv
// Runtime identical-operand checker: flags operator records whose operands match.
// Define LEFTRIGHT_CHECKER_SUPPRESS_COUNT_EN to add the suppress_count output.
module leftright_checker #(
  parameter int W     = 32,
  parameter int TW    = 8,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [W-1:0]  in_left,
  input  logic [W-1:0]  in_right,
  input  logic          in_const,
  input  logic          in_ignore,
  input  logic [TW-1:0] in_tag,
  output logic          warn_valid,
  input  logic          warn_ready,
  output logic [3:0]    warn_op,
  output logic [TW-1:0] warn_tag,
  output logic [CW-1:0] checked_count,
  output logic [CW-1:0] warn_count
`ifdef LEFTRIGHT_CHECKER_SUPPRESS_COUNT_EN
  ,
  output logic [CW-1:0] suppress_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_V = (PW+1)'(DEPTH);

  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_ASHL  = 4'd6;
  localparam logic [3:0] OP_TIMES = 4'd9;
  localparam logic [3:0] OP_RSV   = 4'd14;

  logic          ready_en;
  logic          s1_valid, s2_valid;
  logic [3:0]    s1_op, s2_op;
  logic [W-1:0]  s1_left, s1_right, s2_left, s2_right;
  logic          s1_const, s1_ignore, s2_const, s2_ignore;
  logic [TW-1:0] s1_tag, s2_tag;

  logic [PW-1:0] wr_ptr, rd_ptr, fifo_count;
  logic [3:0]    mem_op  [DEPTH];
  logic [TW-1:0] mem_tag [DEPTH];

  logic          accept, push, pop, empty, full;
  logic          exempt, flagged, hit;
  logic [PW:0]   inflight;

  assign accept     = in_valid && in_ready;
  assign fifo_count = wr_ptr - rd_ptr;
  assign inflight   = {1'b0, fifo_count}
                    + {{PW{1'b0}}, s1_valid}
                    + {{PW{1'b0}}, s2_valid};
  // Reserve a FIFO slot for every record still in the pipeline.
  assign in_ready   = ready_en && (inflight < DEPTH_V);

  always_comb begin
    exempt = 1'b0;
    unique case (1'b1)
      s2_op == OP_TIMES: exempt = 1'b1;
      s2_op >= OP_RSV:   exempt = 1'b1;
      s2_op == OP_SHL || s2_op == OP_ASHL:
        exempt = s2_const && (s2_left == W'(1));
      default:           exempt = 1'b0;
    endcase
  end

  assign flagged = s2_valid && (s2_left == s2_right) && !exempt;
  assign hit     = flagged && !s2_ignore;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = hit;
  assign pop   = warn_valid && warn_ready;

  assign warn_valid = !empty;
  assign warn_op    = warn_valid ? mem_op[rd_ptr[AW-1:0]]  : '0;
  assign warn_tag   = warn_valid ? mem_tag[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en      <= 1'b0;
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      checked_count <= '0;
      warn_count    <= '0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (accept && checked_count != '1)
        checked_count <= checked_count + 1'b1;
      if (push && warn_count != '1)
        warn_count <= warn_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op     <= in_op;
      s1_left   <= in_left;
      s1_right  <= in_right;
      s1_const  <= in_const;
      s1_ignore <= in_ignore;
      s1_tag    <= in_tag;
    end
    s2_op     <= s1_op;
    s2_left   <= s1_left;
    s2_right  <= s1_right;
    s2_const  <= s1_const;
    s2_ignore <= s1_ignore;
    s2_tag    <= s1_tag;
    if (push) begin
      mem_op[wr_ptr[AW-1:0]]  <= s2_op;
      mem_tag[wr_ptr[AW-1:0]] <= s2_tag;
    end
  end

`ifdef LEFTRIGHT_CHECKER_SUPPRESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      suppress_count <= '0;
    else if (flagged && s2_ignore && suppress_count != '1)
      suppress_count <= suppress_count + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(pop && empty));
      assert (!(push && full));
    end
  end

endmodule
